// File: rtl/systolic_ctrl_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COMPUTE = 3'd2,
    READ    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int DEF_DIM = 8;
  localparam int DEF_K   = 8;

  // Cycles needed to push K elements through the diagonal skew of a DIM x DIM array.
  function automatic int compute_len(input int dim, input int k);
    return k + 2 * (dim - 1);
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Control/handshake bundle between the front-end, the sequencer and the systolic array.
interface systolic_ctrl_if import systolic_pkg::*; #(parameter int DIM = DEF_DIM) ();

  logic                    start;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic                    mac_en;
  logic                    mac_wren;
  logic                    c_zero;
  logic [$clog2(DIM)-1:0]  c_row;
  logic [DIM-1:0]          a_lane_en;
  logic [DIM-1:0]          b_lane_en;
  logic                    cout_valid;
  logic                    cout_ready;
  logic [31:0]             perf_cycles;

  modport master (
    input  start, abort, cout_ready,
    output busy, done, mac_en, mac_wren, c_zero, c_row,
           a_lane_en, b_lane_en, cout_valid, perf_cycles
  );

  modport slave (
    output start, abort, cout_ready,
    input  busy, done, mac_en, mac_wren, c_zero, c_row,
           a_lane_en, b_lane_en, cout_valid, perf_cycles
  );

endinterface

// File: rtl/systolic_ctrl_skew.sv
// Diagonal feed skew: lane r (row of A / column of B) is fed during phases r .. r+K-1.
module systolic_skew #(
  parameter int DIM = 8,
  parameter int K   = 8,
  parameter int CW  = 5
) (
  input  logic [CW-1:0]  t,
  input  logic           active,
  output logic [DIM-1:0] a_lane_en,
  output logic [DIM-1:0] b_lane_en
);

  // Per-lane window decode; B columns share the A row timing.
  always_comb begin
    a_lane_en = {DIM{1'b0}};
    for (int r = 0; r < DIM; r++) begin
      if (active && (t >= CW'(r)) && (t < CW'(r + K))) begin
        a_lane_en[r] = 1'b1;
      end else begin
        a_lane_en[r] = 1'b0;
      end
    end
    b_lane_en = a_lane_en;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Pass sequencer for a DIM x DIM tpumac array: clear C, stream skewed A/B, read C, pulse done.
// Optional pass cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl import systolic_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int K   = DEF_K,
  parameter int CW  = $clog2(K + 2 * DIM)
) (
  input  logic            clk,
  input  logic            rst,
  systolic_ctrl_if.master bus
);

  localparam int            RW       = $clog2(DIM);
  localparam int            CLEN     = compute_len(DIM, K);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_T   = CW'(CLEN - 1);

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            compute_s;
  logic [DIM-1:0]  a_lane_s, b_lane_s;

  logic            busy_r, done_r, mac_en_r, mac_wren_r, c_zero_r, cout_valid_r;
  logic [RW-1:0]   c_row_r;
  logic [DIM-1:0]  a_lane_r, b_lane_r;

  // Next state and phase counter; abort beats every other transition in active states.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
        cnt_s = CNT_ZERO;
      end
      CLEAR: begin
        if (bus.abort) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == LAST_ROW) begin
          state_s = COMPUTE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      COMPUTE: begin
        if (bus.abort) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == LAST_T) begin
          state_s = READ;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      READ: begin
        // cout_valid is always high here, so cout_ready alone completes the handshake
        if (bus.abort) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (bus.cout_ready && (cnt_r == LAST_ROW)) begin
          state_s = DONE;
          cnt_s   = CNT_ZERO;
        end else if (bus.cout_ready) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  assign compute_s = (state_s == COMPUTE);

  systolic_skew #(.DIM(DIM), .K(K), .CW(CW)) u_skew (
    .t         (cnt_s),
    .active    (compute_s),
    .a_lane_en (a_lane_s),
    .b_lane_en (b_lane_s)
  );

  // State register plus Moore outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      mac_en_r     <= 1'b0;
      mac_wren_r   <= 1'b0;
      c_zero_r     <= 1'b0;
      cout_valid_r <= 1'b0;
      c_row_r      <= {RW{1'b0}};
      a_lane_r     <= {DIM{1'b0}};
      b_lane_r     <= {DIM{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == DONE);
      mac_en_r     <= compute_s;
      mac_wren_r   <= (state_s == CLEAR);
      c_zero_r     <= (state_s == CLEAR);
      cout_valid_r <= (state_s == READ);
      c_row_r      <= ((state_s == CLEAR) || (state_s == READ)) ? cnt_s[RW-1:0] : {RW{1'b0}};
      a_lane_r     <= a_lane_s;
      b_lane_r     <= b_lane_s;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.mac_en     = mac_en_r;
  assign bus.mac_wren   = mac_wren_r;
  assign bus.c_zero     = c_zero_r;
  assign bus.cout_valid = cout_valid_r;
  assign bus.c_row      = c_row_r;
  assign bus.a_lane_en  = a_lane_r;
  assign bus.b_lane_en  = b_lane_r;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_r;

  // Cleared on an accepted start, counts busy cycles, saturates, frozen while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= 32'd0;
    end else if ((state_r == IDLE) && bus.start && !bus.abort) begin
      perf_r <= 32'd0;
    end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.perf_cycles = perf_r;
`else
  assign bus.perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized self-checking bench for systolic_ctrl (DIM=4, K=4) against a phase-timeline model.
module tb_systolic_ctrl;

  localparam int DIM = 4;
  localparam int K   = 4;
  localparam int RW  = $clog2(DIM);
  localparam int CL  = K + 2 * (DIM - 1);
  localparam int VW  = 6 + RW + 2 * DIM;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  systolic_ctrl_if #(.DIM(DIM)) bus ();

  systolic_ctrl #(.DIM(DIM), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] observed();
    return {bus.busy, bus.done, bus.mac_en, bus.mac_wren, bus.c_zero, bus.cout_valid,
            bus.c_row, bus.a_lane_en, bus.b_lane_en};
  endfunction

  function automatic logic [VW-1:0] pack(input logic busy, input logic done, input logic en,
                                         input logic wren, input logic zero, input logic valid,
                                         input logic [RW-1:0] row, input logic [DIM-1:0] a,
                                         input logic [DIM-1:0] b);
    return {busy, done, en, wren, zero, valid, row, a, b};
  endfunction

  // Lane r carries data during phases r .. r+K-1 of the compute window.
  function automatic logic [DIM-1:0] lanes(input int t);
    logic [DIM-1:0] l;
    for (int r = 0; r < DIM; r++) l[r] = (t >= r) && (t < r + K);
    return l;
  endfunction

  function automatic logic [63:0] perf_exp(input int n);
`ifdef SYSTOLIC_CTRL_PERF_EN
    return 64'(n);
`else
    return 64'd0;
`endif
  endfunction

  // mode 0: cout_ready tied high, 1: random, 2: fixed pattern then random
  task automatic run_pass(input int mode, input int abort_j, input bit noise);
    int             j, hs, nbusy, pi, done_seen, done_j;
    bit             fin, aborted, is_done;
    logic [VW-1:0]  e;
    logic           rdy;
    logic           pat [0:6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    j = 1; hs = 0; nbusy = 0; pi = 0; done_seen = 0; done_j = 0;
    fin = 1'b0; aborted = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!fin) begin
      is_done = 1'b0;
      rdy = 1'($urandom_range(0, 1));
      if (j <= DIM) begin
        e = pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, RW'(j - 1), {DIM{1'b0}}, {DIM{1'b0}});
      end else if (j <= DIM + CL) begin
        e = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}, lanes(j - DIM - 1), lanes(j - DIM - 1));
      end else if (hs < DIM) begin
        e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RW'(hs), {DIM{1'b0}}, {DIM{1'b0}});
        if (mode == 0) rdy = 1'b1;
        else if (mode == 2 && pi < 7) begin rdy = pat[pi]; pi++; end
      end else begin
        e = pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {RW{1'b0}}, {DIM{1'b0}}, {DIM{1'b0}});
        is_done = 1'b1;
        done_j = j;
      end
      bus.cout_ready = rdy;
      bus.start = (noise && !is_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.abort = (j == abort_j) ? 1'b1 : 1'b0;
      check($sformatf("cycle%0d", j), 64'(observed()), 64'(e));
      nbusy++;
      if (bus.done) done_seen++;
      @(posedge clk); #1;
      if (is_done) fin = 1'b1;
      else if (j == abort_j) begin aborted = 1'b1; fin = 1'b1; end
      else if (j > DIM + CL && hs < DIM && rdy) hs++;
      j++;
      if (!fin && j > 400) begin
        check("timeout", 64'(j), 64'd400);
        fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (mode == 0 && !aborted) check("latency", 64'(done_j), 64'(1 + DIM + CL + DIM));
    for (int k = 0; k < 3; k++) begin
      check("idle_after", 64'(observed()), 64'd0);
      check("perf_hold", 64'(bus.perf_cycles), perf_exp(nbusy));
      if (bus.done) done_seen++;
      @(posedge clk); #1;
    end
    check("done_count", 64'(done_seen), aborted ? 64'd0 : 64'd1);
  endtask

  initial begin
    int aj;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cout_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", 64'(observed()), 64'd0);
    check("reset_perf", 64'(bus.perf_cycles), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_pass(0, -1, 1'b0);
    run_pass(2, -1, 1'b0);
    run_pass(0, DIM + 1 + 5, 1'b0);
    run_pass(0, -1, 1'b0);

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_wins", 64'(observed()), 64'd0);
    @(posedge clk); #1;
    check("idle_abort_still", 64'(observed()), 64'd0);

    for (int i = 0; i < 6; i++) begin
      aj = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, DIM + CL + DIM + 1));
      run_pass(1, aj, 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // async reset in the middle of READ
    bus.cout_ready = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (DIM + CL) @(posedge clk);
    #1;
    check("in_read", 64'(bus.cout_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", 64'({bus.busy, bus.cout_valid, bus.mac_en}), 64'd0);
    check("rst_perf", 64'(bus.perf_cycles), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_pass(0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
